// File: rtl/gb_video_pkg.sv
// gb_video_pkg: shared definitions for the Game Boy video transmit path.
//   - STAT mode encoding (gb_mode_e) and the transmit FSM states (tx_state_e)
//   - LCD geometry constants (screen size, dots per line, lines per frame)
//   - rgb555_t: RGB555 pixel layout (bits [4:0] R, [9:5] G, [14:10] B)
//   - state_mode(): maps an FSM state to the STAT mode it reports
package gb_video_pkg;

  localparam int GB_SCREEN_WIDTH    = 160;
  localparam int GB_SCREEN_HEIGHT   = 144;
  localparam int GB_DOTS_PER_LINE   = 456;
  localparam int GB_LINES_PER_FRAME = 154;
  localparam int GB_OAM_DOTS        = 80;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_DRAW   = 2'd3
  } gb_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OAM    = 3'd1,
    ST_DRAW   = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VBLANK = 3'd4
  } tx_state_e;

  typedef struct packed {
    logic       pad;
    logic [4:0] b;
    logic [4:0] g;
    logic [4:0] r;
  } rgb555_t;

  // IDLE reports mode 0, the same value the LCD shows while switched off.
  function automatic gb_mode_e state_mode(input tx_state_e s);
    gb_mode_e m;
    case (s)
      ST_OAM:    m = MODE_OAM;
      ST_DRAW:   m = MODE_DRAW;
      ST_VBLANK: m = MODE_VBLANK;
      default:   m = MODE_HBLANK;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/gb_lcd_timing.sv
// gb_lcd_timing: dot/line raster counters for the Game Boy LCD.
// Ports:
//   clock, clock_rst_b : dot clock, asynchronous active-low reset
//   run                : counters advance one dot per cycle while high
//   clear              : synchronous return of both counters to 0 (LCD off)
//   dot  [8:0]         : 0..DOTS_PER_LINE-1
//   line [7:0]         : LY, 0..LINES_PER_FRAME-1
//   line_next [7:0]    : value line takes after this cycle (ignores clear)
//   line_end           : last dot of the current line (only while running)
//   frame_end          : last dot of the last line of the frame
module gb_lcd_timing
  import gb_video_pkg::*;
#(
  parameter int DOTS_PER_LINE   = GB_DOTS_PER_LINE,
  parameter int LINES_PER_FRAME = GB_LINES_PER_FRAME
) (
  input  logic       clock,
  input  logic       clock_rst_b,
  input  logic       run,
  input  logic       clear,
  output logic [8:0] dot,
  output logic [7:0] line,
  output logic [7:0] line_next,
  output logic       line_end,
  output logic       frame_end
);

  localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
  localparam logic [7:0] LAST_LINE = 8'(LINES_PER_FRAME - 1);

  assign line_end  = run && (dot == LAST_DOT);
  assign frame_end = line_end && (line == LAST_LINE);

  always_comb begin
    line_next = line;
    if (line_end) begin
      line_next = frame_end ? 8'd0 : line + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge clock_rst_b) begin
    if (!clock_rst_b) begin
      dot  <= '0;
      line <= '0;
    end else if (clear) begin
      dot  <= '0;
      line <= '0;
    end else if (run) begin
      if (line_end) begin
        dot  <= '0;
        line <= line_next;
      end else begin
        dot <= dot + 9'd1;
      end
    end
  end

endmodule

// File: rtl/gb_video_tx.sv
// gb_video_tx: transmit end of the Game Boy pixel stream.
// Generates LCD timing (dots x lines), accepts RGB555 pixels from the PPU
// during DRAW and emits a registered write stream to the framebuffer
// converter.
// Ports:
//   clock, clock_rst_b        : dot clock, asynchronous active-low reset
//   lcd_on                    : LCDC.7; low forces IDLE on the next cycle
//   pix_in[15:0], pix_valid   : pixel offer from the PPU pixel pipe
//   pix_ready                 : high only while in DRAW
//   pixel_data, gb_pixel_count, gb_line_count, gb_we : write stream
//   gb_hsync / gb_vsync       : HBLANK / VBLANK indicators
//   mode[1:0]                 : STAT mode
//   underrun                  : sticky, a visible line ended short of pixels
//   state_dbg[2:0]            : current FSM state (tx_state_e encoding)
// Optional feature macro GB_VIDEO_TX_LYC_EN adds lyc[7:0] in,
// lyc_match and lyc_irq out.
//
// Handshake: a pixel transfers on every rising edge where pix_valid and
// pix_ready are both 1. pix_ready is a register decoded from the FSM state
// and never depends combinationally on pix_valid; the PPU may hold
// pix_valid low for any number of cycles (a stall), and pix_in is only
// looked at on a transfer edge.
module gb_video_tx
  import gb_video_pkg::*;
#(
  parameter int DOTS_PER_LINE   = GB_DOTS_PER_LINE,
  parameter int LINES_PER_FRAME = GB_LINES_PER_FRAME,
  parameter int ACTIVE_LINES    = GB_SCREEN_HEIGHT,
  parameter int ACTIVE_PIXELS   = GB_SCREEN_WIDTH,
  parameter int OAM_DOTS        = GB_OAM_DOTS
) (
  input  logic        clock,
  input  logic        clock_rst_b,
  input  logic        lcd_on,
  input  logic [15:0] pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [15:0] pixel_data,
  output logic [7:0]  gb_pixel_count,
  output logic [7:0]  gb_line_count,
  output logic        gb_we,
  output logic        gb_hsync,
  output logic        gb_vsync,
  output logic [1:0]  mode,
  output logic        underrun,
`ifdef GB_VIDEO_TX_LYC_EN
  input  logic [7:0]  lyc,
  output logic        lyc_match,
  output logic        lyc_irq,
`endif
  output logic [2:0]  state_dbg
);

  localparam logic [8:0] LAST_OAM_DOT     = 9'(OAM_DOTS - 1);
  localparam logic [7:0] LAST_X           = 8'(ACTIVE_PIXELS - 1);
  localparam logic [7:0] LAST_ACTIVE_LINE = 8'(ACTIVE_LINES - 1);

  tx_state_e  state;
  tx_state_e  state_next;
  tx_state_e  after_line;
  logic [7:0] x;
  logic       lcd_on_q;
  logic       accept;
  logic       last_pixel;
  logic       underrun_set;

  logic [8:0] dot;
  logic [7:0] line;
  logic [7:0] line_next;
  logic       line_end;
  logic       frame_end;

  gb_lcd_timing #(
    .DOTS_PER_LINE  (DOTS_PER_LINE),
    .LINES_PER_FRAME(LINES_PER_FRAME)
  ) u_timing (
    .clock      (clock),
    .clock_rst_b(clock_rst_b),
    .run        (state != ST_IDLE),
    .clear      (!lcd_on),
    .dot        (dot),
    .line       (line),
    .line_next  (line_next),
    .line_end   (line_end),
    .frame_end  (frame_end)
  );

  assign state_dbg  = state;
  assign accept     = pix_valid && pix_ready;
  assign last_pixel = accept && (x == LAST_X);
  // Where a line goes once its last dot is reached: the line after the
  // last visible one opens VBLANK, any other starts with OAM search.
  assign after_line = (line == LAST_ACTIVE_LINE) ? ST_VBLANK : ST_OAM;

  always_comb begin
    state_next   = state;
    underrun_set = 1'b0;
    case (state)
      ST_IDLE:   state_next = ST_OAM;
      ST_OAM:    if (dot == LAST_OAM_DOT) state_next = ST_DRAW;
      ST_DRAW: begin
        // Line length is fixed: reaching the last dot ends DRAW whether or
        // not the line is complete. A 160th pixel taken on that very dot
        // still counts as a complete line.
        if (line_end) begin
          state_next   = after_line;
          underrun_set = !last_pixel;
        end else if (last_pixel) begin
          state_next = ST_HBLANK;
        end
      end
      ST_HBLANK: if (line_end) state_next = after_line;
      ST_VBLANK: if (frame_end) state_next = ST_OAM;
      default:   state_next = ST_IDLE;
    endcase
    if (!lcd_on) begin
      state_next   = ST_IDLE;
      underrun_set = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge clock_rst_b) begin
    if (!clock_rst_b) begin
      state          <= ST_IDLE;
      x              <= '0;
      lcd_on_q       <= 1'b0;
      pix_ready      <= 1'b0;
      pixel_data     <= '0;
      gb_pixel_count <= '0;
      gb_line_count  <= '0;
      gb_we          <= 1'b0;
      gb_hsync       <= 1'b0;
      gb_vsync       <= 1'b0;
      mode           <= MODE_HBLANK;
      underrun       <= 1'b0;
    end else begin
      lcd_on_q  <= lcd_on;
      state     <= state_next;
      pix_ready <= (state_next == ST_DRAW);
      mode      <= state_mode(state_next);
      gb_hsync  <= (state_next == ST_HBLANK);
      gb_vsync  <= (state_next == ST_VBLANK);

      // underrun survives LCD-off and is only cleared by switching back on.
      if (lcd_on && !lcd_on_q) begin
        underrun <= 1'b0;
      end else if (underrun_set) begin
        underrun <= 1'b1;
      end

      if (!lcd_on) begin
        x              <= '0;
        pixel_data     <= '0;
        gb_pixel_count <= '0;
        gb_line_count  <= '0;
        gb_we          <= 1'b0;
      end else begin
        gb_we <= accept;
        if (accept) begin
          pixel_data     <= pix_in;
          gb_pixel_count <= x;
          // The write carries the line it was accepted on, even when it
          // lands in the first cycle of the next line.
          gb_line_count  <= line;
          x              <= x + 8'd1;
        end else begin
          gb_line_count <= line_next;
        end
        if (state_next == ST_DRAW && state != ST_DRAW) begin
          x <= '0;
        end
      end
    end
  end

`ifdef GB_VIDEO_TX_LYC_EN
  logic match_next;
  assign match_next = (state_next != ST_IDLE) && (line_next == lyc);

  always_ff @(posedge clock or negedge clock_rst_b) begin
    if (!clock_rst_b) begin
      lyc_match <= 1'b0;
      lyc_irq   <= 1'b0;
    end else begin
      lyc_match <= match_next;
      lyc_irq   <= match_next && !lyc_match;
    end
  end
`endif

endmodule
